// File: rtl/riscv_defines.sv
// Shared types for the instruction fetch path: memory-side FSM states and
// the {address, data} word carried through the prefetch FIFO.
package riscv_defines;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_WAIT_GNT,
    FETCH_WAIT_RVALID,
    FETCH_WAIT_ABORTED
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;

  localparam logic [1:0] OPC_32BIT = 2'b11;

  function automatic logic is_32bit(input logic [1:0] lsb);
    return lsb == OPC_32BIT;
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Prefetch word FIFO. Exposes the head and the entry behind it so the
// realigner can stitch instructions that straddle a word boundary.
module riscv_fetch_fifo
  import riscv_defines::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_entry,
  output logic [CW-1:0] o_count,
  output fetch_entry_t o_head,
  output fetch_entry_t o_next
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_entry;
        r_wr        <= r_wr + PW'(1);
      end
      if (i_pop) begin
        r_rd <= r_rd + PW'(1);
      end
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
  assign o_next  = r_mem[r_rd + PW'(1)];

endmodule

// File: rtl/riscv_fetch_realign_buffer.sv
// Prefetch/realign buffer in front of IF: word-aligned memory fetches,
// halfword-realigned instruction delivery, branch and hwloop redirects.
module riscv_fetch_realign_buffer
  import riscv_defines::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        hwloop_i,
  input  logic [31:0] hwloop_target_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        is_hwlp_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  r_state;
  fetch_state_e  w_state_next;
  logic [31:0]   r_fetch_addr;
  logic [31:0]   w_fetch_addr_next;
  logic [31:0]   r_addr;
  logic          r_hwlp;

  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_next;
  logic          w_push;
  logic          w_pop;
  logic          w_cnt_ge1;
  logic          w_cnt_ge2;
  logic [31:0]   w_rdata;
  logic          w_valid_raw;
  logic          w_consume;
  logic          w_is32;
  logic          w_hwlp_take;
  logic          w_redirect;
  logic [31:0]   w_target;
  logic [31:0]   w_target_word;
  logic          w_credit;
  logic          w_credit_after;
  logic          w_unused;

  riscv_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_entry ({r_fetch_addr, instr_rdata_i}),
    .o_count (w_count),
    .o_head  (w_head),
    .o_next  (w_next)
  );

  assign w_unused = ^{w_head.addr, w_next.addr, w_next.data[31:16]};

  assign w_cnt_ge1 = (w_count != '0);
  assign w_cnt_ge2 = (w_count >= CW'(2));

  always_comb begin
    w_rdata     = w_head.data;
    w_valid_raw = w_cnt_ge1;
    if (r_addr[1]) begin
      if (!is_32bit(w_head.data[17:16])) begin
        w_rdata = {(w_cnt_ge2 ? w_next.data[15:0] : 16'h0000), w_head.data[31:16]};
      end else begin
        w_rdata     = {w_next.data[15:0], w_head.data[31:16]};
        w_valid_raw = w_cnt_ge2;
      end
    end
  end

  assign valid_o       = w_valid_raw & ~branch_i;
  assign rdata_o       = w_rdata;
  assign addr_o        = r_addr;
  assign is_hwlp_o     = r_hwlp;
  assign w_consume     = valid_o & ready_i;
  assign w_is32        = is_32bit(w_rdata[1:0]);
  assign w_hwlp_take   = w_consume & hwloop_i;
  assign w_redirect    = branch_i | w_hwlp_take;
  assign w_target      = branch_i ? addr_i : hwloop_target_i;
  assign w_target_word = {w_target[31:2], 2'b00};
  // An aligned compressed instruction leaves its upper half in the head word.
  assign w_pop         = w_consume & (r_addr[1] | w_is32);

  assign w_credit       = (32'(w_count) + 32'(r_state == FETCH_WAIT_RVALID)) < DEPTH;
  assign w_credit_after = (32'(w_count) + 32'd1 - 32'(w_pop)) < DEPTH;

  always_comb begin
    w_state_next      = r_state;
    w_fetch_addr_next = r_fetch_addr;
    instr_req_o       = 1'b0;
    instr_addr_o      = r_fetch_addr;
    w_push            = 1'b0;

    unique case (r_state)
      FETCH_IDLE: begin
        instr_req_o = req_i & w_credit;
        if (instr_req_o) begin
          w_state_next = instr_gnt_i ? FETCH_WAIT_RVALID : FETCH_WAIT_GNT;
        end
      end
      FETCH_WAIT_GNT: begin
        instr_req_o = 1'b1;
        if (instr_gnt_i) begin
          w_state_next = FETCH_WAIT_RVALID;
        end
      end
      FETCH_WAIT_RVALID: begin
        if (instr_rvalid_i) begin
          w_push            = 1'b1;
          w_fetch_addr_next = r_fetch_addr + 32'd4;
          instr_addr_o      = r_fetch_addr + 32'd4;
          instr_req_o       = req_i & w_credit_after;
          if (instr_req_o) begin
            w_state_next = instr_gnt_i ? FETCH_WAIT_RVALID : FETCH_WAIT_GNT;
          end else begin
            w_state_next = FETCH_IDLE;
          end
        end
      end
      FETCH_WAIT_ABORTED: begin
        if (instr_rvalid_i) begin
          instr_req_o = req_i & w_credit;
          if (instr_req_o) begin
            w_state_next = instr_gnt_i ? FETCH_WAIT_RVALID : FETCH_WAIT_GNT;
          end else begin
            w_state_next = FETCH_IDLE;
          end
        end
      end
      default: w_state_next = FETCH_IDLE;
    endcase

    // A redirect overrides the normal sequence; while an rvalid is still owed
    // the new request waits for it so the stale word can be dropped.
    if (w_redirect) begin
      w_push            = 1'b0;
      w_fetch_addr_next = w_target_word;
      if ((r_state == FETCH_WAIT_RVALID || r_state == FETCH_WAIT_ABORTED) && !instr_rvalid_i) begin
        instr_req_o  = 1'b0;
        w_state_next = FETCH_WAIT_ABORTED;
      end else begin
        instr_req_o  = 1'b1;
        instr_addr_o = w_target_word;
        w_state_next = instr_gnt_i ? FETCH_WAIT_RVALID : FETCH_WAIT_GNT;
      end
    end
  end

  assign busy_o = (r_state != FETCH_IDLE) | instr_req_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FETCH_IDLE;
      r_fetch_addr <= '0;
      r_addr       <= '0;
      r_hwlp       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_fetch_addr <= w_fetch_addr_next;
      if (w_redirect) begin
        r_addr <= w_target;
        r_hwlp <= ~branch_i;
      end else if (w_consume) begin
        r_addr <= r_addr + (w_is32 ? 32'd4 : 32'd2);
        r_hwlp <= 1'b0;
      end
    end
  end

endmodule
